pktctrl_framer_p: RTL and testbench
===================================

// Module: pktctrl_framer_p
// PURPOSE
//  Parametrised successor to the ADC packet controller. Captures NCH-channel ADC
//  snapshots (or an internal counting test pattern), frames them into packets
//  (header + payload + idle gap) and serialises them as OUT_W-bit words to the
//  capture interface under DATA_RD_EN flow control. Adds a channel mask,
//  continuous mode, a packet sequence number and overflow detection.
// PARAMETERS
//  NCH    24  number of ADC channels (1..64)
//  DW     36  bits per channel sample; DW % OUT_W == 0
//  OUT_W  18  output word width (>= 4)
// PORTS
//  pktctrl_clk         in   1          single clock for the whole block
//  pktctrl_rstn        in   1          asynchronous active-low reset
//  rf_capture_start    in   1          pulse: start capture (ignored while pkt_busy)
//  rf_capture_stop     in   1          pulse: end continuous mode after current packet
//  rf_capture_mode     in   1          0 = single packet, 1 = continuous
//  rf_self_test_mode   in   1          1 = payload uses the internal test pattern
//  rf_ch_mask          in   NCH        channel enable; all-zero is treated as ch0 only
//  rf_pkt_data_length  in   16         snapshots per packet; 0 is treated as 1
//  rf_pkt_idle_length  in   16         idle cycles between packets
//  adc_data            in   NCH*DW     ch c = adc_data[c*DW +: DW]
//  adc_data_valid      in   1          snapshot strobe
//  DATA_RD_EN          in   1          downstream accept
//  ADC_DATA            out  OUT_W      output word
//  ADC_DATA_VALID      out  1          output word valid
//  pkt_busy            out  1          state != IDLE
//  pkt_overflow        out  1          sticky; snapshot dropped
//  pkt_seq             out  16         sequence number of the next header
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; snapshot/seq/test counters cleared.
//  - Transfer: a word moves when ADC_DATA_VALID & DATA_RD_EN. While valid and not
//    accepted, ADC_DATA and ADC_DATA_VALID hold stable.
//  - FSM states: IDLE, HDR, WAIT_SNAP, SEND, GAP.
//    IDLE -> HDR on rf_capture_start. ADC_DATA_VALID rises the next cycle.
//      pkt_overflow is cleared on that start.
//    HDR: word = {2'b11, pkt_seq[OUT_W-3:0]}, zero-padded if OUT_W > 18.
//      On accept: pkt_seq++ (wraps at 16 bits) and go to WAIT_SNAP.
//    WAIT_SNAP: ADC_DATA_VALID = 0. On adc_data_valid, latch the snapshot into the
//      holding register and go to SEND.
//    SEND: for each enabled channel in ascending order, emit DW/OUT_W words,
//      least-significant slice first. Masked channels consume no cycles.
//      On accepting the last word of a snapshot, snap_cnt++. Then go to GAP if
//      snap_cnt == len-1, else WAIT_SNAP.
//    GAP: ADC_DATA_VALID = 0 for exactly rf_pkt_idle_length cycles; 0 skips GAP.
//      At the end: continuous with no stop pending -> HDR; otherwise IDLE.
//  - rf_capture_stop sets stop_pend (cleared in IDLE). It never truncates a packet.
//  - Self-test: at latch time, ch c = (test_cnt + c) zero-extended to DW.
//    test_cnt is 16 bits, increments per latched snapshot and wraps.
//  - Overflow: adc_data_valid in HDR/SEND/GAP while the capture is active drops
//    that snapshot and sets pkt_overflow. No other effect.
//  - rf_ch_mask, rf_pkt_*_length and rf_self_test_mode are sampled at HDR entry
//    and held constant for the packet.
//  - Async reset mid-packet aborts immediately. No partial word survives.
// TESTING
//  1 NCH=24, mask=all-ones, len=1, idle=4, single, RD_EN=1, adc ch c = c
//    -> header 0x30000, then 48 words (ch c: c, 0), 4 idle cycles, IDLE, pkt_seq=1.
//  2 mask=0x000005, len=2, self-test, test_cnt=0
//    -> header, words 0,0,2,0, then 1,0,3,0; pkt_busy falls after GAP.
//  3 RD_EN toggles 1/0 every cycle in scenario 1
//    -> same 49-word sequence; data held stable during every stalled cycle.
//  4 continuous, idle=0, stop pulse midway through packet 3
//    -> packets 0..2 complete back-to-back; headers carry seq 0,1,2; then IDLE.
//  5 adc_data_valid asserted every cycle -> pkt_overflow=1;
//    next rf_capture_start clears it.
//  6 reset asserted during SEND -> all outputs 0 asynchronously;
//    after release, a start yields header with seq 0.

Source files
------------

// File: rtl/pktctrl_framer_p.sv
// pktctrl_framer_p: frames NCH-channel ADC snapshots into header/payload/gap packets
// and serialises them as OUT_W-bit words under DATA_RD_EN flow control.
module pktctrl_framer_p #(
    parameter int unsigned NCH   = 24,
    parameter int unsigned DW    = 36,
    parameter int unsigned OUT_W = 18
) (
    input  logic                 pktctrl_clk,
    input  logic                 pktctrl_rstn,
    input  logic                 rf_capture_start,
    input  logic                 rf_capture_stop,
    input  logic                 rf_capture_mode,
    input  logic                 rf_self_test_mode,
    input  logic [NCH-1:0]       rf_ch_mask,
    input  logic [15:0]          rf_pkt_data_length,
    input  logic [15:0]          rf_pkt_idle_length,
    input  logic [NCH*DW-1:0]    adc_data,
    input  logic                 adc_data_valid,
    input  logic                 DATA_RD_EN,
    output logic [OUT_W-1:0]     ADC_DATA,
    output logic                 ADC_DATA_VALID,
    output logic                 pkt_busy,
    output logic                 pkt_overflow,
    output logic [15:0]          pkt_seq
);

    localparam int unsigned SPW = DW / OUT_W;
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SW  = (SPW > 1) ? $clog2(SPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WAIT_SNAP,
        S_SEND,
        S_GAP
    } state_t;

    state_t              state_q;
    logic [OUT_W-1:0]    data_q;
    logic                valid_q;
    logic                overflow_q;
    logic                stop_pend_q;
    logic                mode_q;
    logic                st_q;
    logic [15:0]         seq_q;
    logic [15:0]         test_cnt_q;
    logic [15:0]         snap_cnt_q;
    logic [15:0]         gap_cnt_q;
    logic [15:0]         len_q;
    logic [15:0]         idle_q;
    logic [NCH-1:0]      mask_q;
    logic [NCH*DW-1:0]   hold_q;
    logic [CHW-1:0]      ch_q;
    logic [SW-1:0]       slice_q;

    logic                accept_d;
    logic [NCH*DW-1:0]   self_d;
    logic [NCH*DW-1:0]   snap_d;
    logic [CHW:0]        first_d;
    logic [CHW:0]        next_d;
    logic                last_slice_d;
    logic                last_word_d;
    logic                last_snap_d;
    logic                pkt_end_d;
    logic                enter_hdr_d;
    logic [OUT_W-1:0]    hdr_word_d;
    logic [NCH-1:0]      mask_eff_d;
    logic [15:0]         len_eff_d;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [CHW:0] find_ch(input logic [NCH-1:0] m, input int unsigned from);
        logic [CHW:0] r;
        r = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!r[CHW] && (c >= from) && m[c]) begin
                r = {1'b1, CHW'(c)};
            end
        end
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] word_of(input logic [NCH*DW-1:0] s,
                                                 input logic [CHW-1:0]    c,
                                                 input logic [SW-1:0]     k);
        int unsigned idx;
        idx = 32'(c) * DW + 32'(k) * OUT_W;
        return s[idx +: OUT_W];
    endfunction

    always_comb begin
        self_d = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            self_d[c*DW +: DW] = DW'(test_cnt_q + 16'(c));
        end
        snap_d = st_q ? self_d : adc_data;
    end

    always_comb begin
        accept_d     = valid_q & DATA_RD_EN;
        first_d      = find_ch(mask_q, 0);
        next_d       = find_ch(mask_q, 32'(ch_q) + 32'd1);
        last_slice_d = (slice_q == SW'(SPW - 1));
        last_word_d  = last_slice_d && !next_d[CHW];
        last_snap_d  = (snap_cnt_q == len_q - 16'd1);
        hdr_word_d   = {2'b11, (OUT_W-2)'(seq_q)};
        mask_eff_d   = (rf_ch_mask == '0) ? NCH'(1) : rf_ch_mask;
        len_eff_d    = (rf_pkt_data_length == '0) ? 16'd1 : rf_pkt_data_length;
        // A packet ends either on the last payload word (no gap) or on the last gap cycle.
        pkt_end_d    = ((state_q == S_SEND) && accept_d && last_word_d && last_snap_d &&
                        (idle_q == '0)) ||
                       ((state_q == S_GAP) && (gap_cnt_q == idle_q - 16'd1));
        enter_hdr_d  = ((state_q == S_IDLE) && rf_capture_start) ||
                       (pkt_end_d && mode_q && !stop_pend_q && !rf_capture_stop);
    end

    always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
        if (!pktctrl_rstn) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            mode_q      <= 1'b0;
            st_q        <= 1'b0;
            seq_q       <= '0;
            test_cnt_q  <= '0;
            snap_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            len_q       <= '0;
            idle_q      <= '0;
            mask_q      <= '0;
            hold_q      <= '0;
            ch_q        <= '0;
            slice_q     <= '0;
        end else begin
            if ((state_q != S_IDLE) && rf_capture_stop) begin
                stop_pend_q <= 1'b1;
            end
            if (((state_q == S_HDR) || (state_q == S_SEND) || (state_q == S_GAP)) &&
                adc_data_valid) begin
                overflow_q <= 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    stop_pend_q <= 1'b0;
                    if (rf_capture_start) begin
                        overflow_q <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (accept_d) begin
                        seq_q   <= seq_q + 16'd1;
                        valid_q <= 1'b0;
                        state_q <= S_WAIT_SNAP;
                    end
                end
                S_WAIT_SNAP: begin
                    if (adc_data_valid && first_d[CHW]) begin
                        hold_q  <= snap_d;
                        ch_q    <= first_d[CHW-1:0];
                        slice_q <= '0;
                        data_q  <= word_of(snap_d, first_d[CHW-1:0], '0);
                        valid_q <= 1'b1;
                        state_q <= S_SEND;
                        if (st_q) begin
                            test_cnt_q <= test_cnt_q + 16'd1;
                        end
                    end
                end
                S_SEND: begin
                    if (accept_d) begin
                        if (!last_slice_d) begin
                            slice_q <= slice_q + SW'(1);
                            data_q  <= word_of(hold_q, ch_q, slice_q + SW'(1));
                        end else if (next_d[CHW]) begin
                            ch_q    <= next_d[CHW-1:0];
                            slice_q <= '0;
                            data_q  <= word_of(hold_q, next_d[CHW-1:0], '0);
                        end else begin
                            valid_q    <= 1'b0;
                            snap_cnt_q <= snap_cnt_q + 16'd1;
                            if (!last_snap_d) begin
                                state_q <= S_WAIT_SNAP;
                            end else if (idle_q == '0) begin
                                state_q <= S_IDLE;
                            end else begin
                                gap_cnt_q <= '0;
                                state_q   <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt_q <= gap_cnt_q + 16'd1;
                    if (gap_cnt_q == idle_q - 16'd1) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Header entry overrides any IDLE transition taken above and samples the config.
            if (enter_hdr_d) begin
                state_q    <= S_HDR;
                valid_q    <= 1'b1;
                data_q     <= hdr_word_d;
                snap_cnt_q <= '0;
                mask_q     <= mask_eff_d;
                len_q      <= len_eff_d;
                idle_q     <= rf_pkt_idle_length;
                st_q       <= rf_self_test_mode;
                mode_q     <= rf_capture_mode;
            end
        end
    end

    assign ADC_DATA       = data_q;
    assign ADC_DATA_VALID = valid_q;
    assign pkt_busy       = (state_q != S_IDLE);
    assign pkt_overflow   = overflow_q;
    assign pkt_seq        = seq_q;

endmodule

// File: tb/tb_pktctrl_framer_p.sv
// Self-checking bench for pktctrl_framer_p: a packet model fills an expected-word queue
// that each scenario task drains against accepted DUT output words.
module tb_pktctrl_framer_p;

    localparam int unsigned NCH   = 24;
    localparam int unsigned DW    = 36;
    localparam int unsigned OUT_W = 18;
    localparam int unsigned SPW   = DW / OUT_W;

    logic                clk = 1'b0;
    logic                rstn;
    logic                rf_capture_start;
    logic                rf_capture_stop;
    logic                rf_capture_mode;
    logic                rf_self_test_mode;
    logic [NCH-1:0]      rf_ch_mask;
    logic [15:0]         rf_pkt_data_length;
    logic [15:0]         rf_pkt_idle_length;
    logic [NCH*DW-1:0]   adc_data;
    logic                adc_data_valid;
    logic                DATA_RD_EN;
    logic [OUT_W-1:0]    ADC_DATA;
    logic                ADC_DATA_VALID;
    logic                pkt_busy;
    logic                pkt_overflow;
    logic [15:0]         pkt_seq;

    logic [DW-1:0]       adc_ch [NCH];
    logic [OUT_W-1:0]    exp_q [$];
    logic [15:0]         m_seq;
    logic [15:0]         m_tc;
    int                  n_cmp = 0;
    int                  n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) adc_data[c*DW +: DW] = adc_ch[c];
    end

    pktctrl_framer_p #(.NCH(NCH), .DW(DW), .OUT_W(OUT_W)) dut (
        .pktctrl_clk        (clk),
        .pktctrl_rstn       (rstn),
        .rf_capture_start   (rf_capture_start),
        .rf_capture_stop    (rf_capture_stop),
        .rf_capture_mode    (rf_capture_mode),
        .rf_self_test_mode  (rf_self_test_mode),
        .rf_ch_mask         (rf_ch_mask),
        .rf_pkt_data_length (rf_pkt_data_length),
        .rf_pkt_idle_length (rf_pkt_idle_length),
        .adc_data           (adc_data),
        .adc_data_valid     (adc_data_valid),
        .DATA_RD_EN         (DATA_RD_EN),
        .ADC_DATA           (ADC_DATA),
        .ADC_DATA_VALID     (ADC_DATA_VALID),
        .pkt_busy           (pkt_busy),
        .pkt_overflow       (pkt_overflow),
        .pkt_seq            (pkt_seq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        rf_capture_start = 1'b0;
        rf_capture_stop  = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        m_seq = '0;
        m_tc  = '0;
        exp_q.delete();
    endtask

    task automatic configure(input logic [NCH-1:0] m, input logic [15:0] len,
                             input logic [15:0] idle, input logic mode, input logic st);
        rf_ch_mask         = m;
        rf_pkt_data_length = len;
        rf_pkt_idle_length = idle;
        rf_capture_mode    = mode;
        rf_self_test_mode  = st;
    endtask

    task automatic pulse_start();
        rf_capture_start = 1'b1;
        tick();
        rf_capture_start = 1'b0;
    endtask

    // Reference packet: header, then each enabled channel's slices LS first, per snapshot.
    task automatic push_pkt();
        logic [NCH-1:0] m;
        int unsigned    len;
        logic [DW-1:0]  v;
        m   = (rf_ch_mask == '0) ? NCH'(1) : rf_ch_mask;
        len = (rf_pkt_data_length == '0) ? 1 : int'(rf_pkt_data_length);
        exp_q.push_back({2'b11, m_seq});
        m_seq = m_seq + 16'd1;
        for (int unsigned s = 0; s < len; s++) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (m[c]) begin
                    v = rf_self_test_mode ? DW'(m_tc + 16'(c)) : adc_ch[c];
                    for (int unsigned k = 0; k < SPW; k++) exp_q.push_back(v[k*OUT_W +: OUT_W]);
                end
            end
            if (rf_self_test_mode) m_tc = m_tc + 16'd1;
        end
    endtask

    task automatic test_reset();
        DATA_RD_EN = 1'b1;
        adc_data_valid = 1'b1;
        rstn = 1'b0;
        #3;
        n_cmp++;
        if (ADC_DATA_VALID !== 1'b0 || ADC_DATA !== '0) begin
            n_err++;
            $display("FAIL reset_data: got valid=%b data=%h, expected 0/0", ADC_DATA_VALID, ADC_DATA);
        end
        n_cmp++;
        if (pkt_busy !== 1'b0 || pkt_overflow !== 1'b0 || pkt_seq !== 16'd0) begin
            n_err++;
            $display("FAIL reset_status: got busy=%b ovf=%b seq=%0d, expected 0/0/0",
                     pkt_busy, pkt_overflow, pkt_seq);
        end
        apply_reset();
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (pkt_busy !== 1'b0 || pkt_overflow !== 1'b0 || ADC_DATA_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet: got busy=%b ovf=%b valid=%b, expected 0/0/0",
                     pkt_busy, pkt_overflow, ADC_DATA_VALID);
        end
    endtask

    task automatic test_single_packet();
        logic [OUT_W-1:0] e;
        int gap;
        bit done;
        apply_reset();
        for (int unsigned c = 0; c < NCH; c++) adc_ch[c] = DW'(c);
        configure('1, 16'd1, 16'd4, 1'b0, 1'b0);
        DATA_RD_EN = 1'b1;
        adc_data_valid = 1'b1;
        push_pkt();
        pulse_start();
        gap = 0;
        done = 0;
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            @(negedge clk);
            if (ADC_DATA_VALID && DATA_RD_EN) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL single_extra: got %h, expected no word", ADC_DATA);
                end else begin
                    e = exp_q.pop_front();
                    if (ADC_DATA !== e) begin
                        n_err++;
                        $display("FAIL single_word: got %h, expected %h", ADC_DATA, e);
                    end
                end
            end else if (exp_q.size() == 0 && pkt_busy) gap++;
            done = (exp_q.size() == 0) && !pkt_busy;
            tick();
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL single_timeout: got %0d words left, expected 0 and idle", exp_q.size());
        end
        n_cmp++;
        if (gap !== 4) begin
            n_err++;
            $display("FAIL single_gap: got %0d idle cycles, expected 4", gap);
        end
        n_cmp++;
        if (pkt_seq !== 16'd1) begin
            n_err++;
            $display("FAIL single_seq: got %0d, expected 1", pkt_seq);
        end
    endtask

    task automatic test_mask_selftest();
        logic [OUT_W-1:0] e;
        int gap;
        bit done;
        apply_reset();
        configure(24'h000005, 16'd2, 16'd3, 1'b0, 1'b1);
        DATA_RD_EN = 1'b1;
        adc_data_valid = 1'b1;
        push_pkt();
        pulse_start();
        gap = 0;
        done = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (ADC_DATA_VALID && DATA_RD_EN) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL mask_extra: got %h, expected no word", ADC_DATA);
                end else begin
                    e = exp_q.pop_front();
                    if (ADC_DATA !== e) begin
                        n_err++;
                        $display("FAIL mask_word: got %h, expected %h", ADC_DATA, e);
                    end
                end
            end else if (exp_q.size() == 0 && pkt_busy) gap++;
            done = (exp_q.size() == 0) && !pkt_busy;
            tick();
        end
        n_cmp++;
        if (!done || gap !== 3) begin
            n_err++;
            $display("FAIL mask_gap: got done=%0d gap=%0d, expected 1/3", done, gap);
        end
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] e;
        logic [OUT_W-1:0] hd;
        bit held;
        int gap;
        bit done;
        for (int unsigned c = 0; c < NCH; c++) adc_ch[c] = DW'(c);
        configure('1, 16'd1, 16'd4, 1'b0, 1'b0);
        DATA_RD_EN = 1'b0;
        adc_data_valid = 1'b1;
        push_pkt();
        pulse_start();
        gap = 0;
        done = 0;
        held = 0;
        hd = '0;
        for (int cyc = 0; cyc < 800 && !done; cyc++) begin
            @(negedge clk);
            if (held) begin
                n_cmp++;
                if (ADC_DATA_VALID !== 1'b1 || ADC_DATA !== hd) begin
                    n_err++;
                    $display("FAIL stall_hold: got valid=%b data=%h, expected 1/%h",
                             ADC_DATA_VALID, ADC_DATA, hd);
                end
            end
            held = ADC_DATA_VALID && !DATA_RD_EN;
            hd = ADC_DATA;
            if (ADC_DATA_VALID && DATA_RD_EN) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stall_extra: got %h, expected no word", ADC_DATA);
                end else begin
                    e = exp_q.pop_front();
                    if (ADC_DATA !== e) begin
                        n_err++;
                        $display("FAIL stall_word: got %h, expected %h", ADC_DATA, e);
                    end
                end
            end else if (exp_q.size() == 0 && pkt_busy) gap++;
            done = (exp_q.size() == 0) && !pkt_busy;
            tick();
            DATA_RD_EN = ~DATA_RD_EN;
        end
        n_cmp++;
        if (!done || gap !== 4) begin
            n_err++;
            $display("FAIL stall_end: got done=%0d gap=%0d, expected 1/4", done, gap);
        end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W-1:0] e;
        int popped;
        int busy_low;
        int extra;
        bit stopped;
        bit done;
        apply_reset();
        configure(24'h000003, 16'd2, 16'd0, 1'b1, 1'b1);
        DATA_RD_EN = 1'b1;
        adc_data_valid = 1'b1;
        repeat (3) push_pkt();
        pulse_start();
        popped = 0;
        busy_low = 0;
        stopped = 0;
        done = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (ADC_DATA_VALID && DATA_RD_EN) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL cont_extra: got %h, expected no word", ADC_DATA);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    if (ADC_DATA !== e) begin
                        n_err++;
                        $display("FAIL cont_word: got %h, expected %h (word %0d)", ADC_DATA, e, popped);
                    end
                end
            end
            if (!pkt_busy && exp_q.size() != 0) busy_low++;
            done = (exp_q.size() == 0) && !pkt_busy;
            tick();
            rf_capture_stop = (popped >= 22) && !stopped;
            if (rf_capture_stop) stopped = 1;
        end
        rf_capture_stop = 1'b0;
        n_cmp++;
        if (!done || busy_low !== 0) begin
            n_err++;
            $display("FAIL cont_end: got done=%0d busy_low=%0d, expected 1/0", done, busy_low);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (ADC_DATA_VALID || pkt_busy) extra++;
        end
        n_cmp++;
        if (extra !== 0 || pkt_seq !== 16'd3) begin
            n_err++;
            $display("FAIL cont_stop: got active=%0d seq=%0d, expected 0/3", extra, pkt_seq);
        end
    endtask

    task automatic test_overflow();
        logic [OUT_W-1:0] e;
        bit done;
        apply_reset();
        for (int unsigned c = 0; c < NCH; c++) adc_ch[c] = {$urandom, $urandom};
        configure(24'h800001, 16'd1, 16'd2, 1'b0, 1'b0);
        DATA_RD_EN = 1'b1;
        adc_data_valid = 1'b0;
        push_pkt();
        pulse_start();
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (ADC_DATA_VALID !== 1'b1 || ADC_DATA !== e) begin
            n_err++;
            $display("FAIL ovf_hdr: got valid=%b data=%h, expected 1/%h", ADC_DATA_VALID, ADC_DATA, e);
        end
        tick();
        adc_data_valid = 1'b1;
        tick();
        adc_data_valid = 1'b0;
        done = 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            if (ADC_DATA_VALID && DATA_RD_EN) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ovf_extra: got %h, expected no word", ADC_DATA);
                end else begin
                    e = exp_q.pop_front();
                    if (ADC_DATA !== e) begin
                        n_err++;
                        $display("FAIL ovf_word: got %h, expected %h", ADC_DATA, e);
                    end
                end
            end
            done = (exp_q.size() == 0) && !pkt_busy;
            tick();
        end
        n_cmp++;
        if (!done || pkt_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clean: got done=%0d ovf=%b, expected 1/0", done, pkt_overflow);
        end
        adc_data_valid = 1'b1;
        push_pkt();
        pulse_start();
        repeat (60) tick();
        @(negedge clk);
        n_cmp++;
        if (pkt_overflow !== 1'b1 || pkt_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_set: got ovf=%b busy=%b, expected 1/0", pkt_overflow, pkt_busy);
        end
        tick();
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if (pkt_overflow !== 1'b0 || ADC_DATA_VALID !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_clear: got ovf=%b valid=%b, expected 0/1", pkt_overflow, ADC_DATA_VALID);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [OUT_W-1:0] e;
        int popped;
        apply_reset();
        for (int unsigned c = 0; c < NCH; c++) adc_ch[c] = DW'(c + 1);
        configure('1, 16'd1, 16'd4, 1'b0, 1'b0);
        DATA_RD_EN = 1'b1;
        adc_data_valid = 1'b1;
        push_pkt();
        pulse_start();
        popped = 0;
        for (int cyc = 0; cyc < 100 && popped < 6; cyc++) begin
            @(negedge clk);
            if (ADC_DATA_VALID && DATA_RD_EN && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                popped++;
                n_cmp++;
                if (ADC_DATA !== e) begin
                    n_err++;
                    $display("FAIL abort_word: got %h, expected %h", ADC_DATA, e);
                end
            end
            if (popped < 6) tick();
        end
        #1;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (ADC_DATA_VALID !== 1'b0 || ADC_DATA !== '0 || pkt_busy !== 1'b0 ||
            pkt_seq !== 16'd0 || pkt_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL abort_outputs: got valid=%b data=%h busy=%b seq=%0d ovf=%b, expected all 0",
                     ADC_DATA_VALID, ADC_DATA, pkt_busy, pkt_seq, pkt_overflow);
        end
        exp_q.delete();
        tick();
        rstn = 1'b1;
        tick();
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if (ADC_DATA_VALID !== 1'b1 || ADC_DATA !== 18'h30000) begin
            n_err++;
            $display("FAIL abort_restart: got valid=%b data=%h, expected 1/30000", ADC_DATA_VALID, ADC_DATA);
        end
    endtask

    initial begin
        rstn               = 1'b0;
        rf_capture_start   = 1'b0;
        rf_capture_stop    = 1'b0;
        rf_capture_mode    = 1'b0;
        rf_self_test_mode  = 1'b0;
        rf_ch_mask         = '0;
        rf_pkt_data_length = '0;
        rf_pkt_idle_length = '0;
        adc_data_valid     = 1'b0;
        DATA_RD_EN         = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) adc_ch[c] = '0;
        test_reset();
        test_single_packet();
        test_mask_selftest();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
